ddr2_64bit_ex_lfsr8_chk: RTL and testbench

Receive-side checker for the 8-bit LFSR test pattern used by the DDR2 example driver. It sits on one byte lane of the read-data return path. It regenerates the expected byte sequence from the same polynomial and seed as the write-side generator, and can self-align to a stream that starts mid-sequence. Once locked, it flags and counts mismatching bytes for the driver's pass/fail logic.

---
 rtl/ddr2_64bit_ex_lfsr8_chk.sv | 144 ++++++++++++++
 tb/tb_ddr2_64bit_ex_lfsr8_chk.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_64bit_ex_lfsr8_chk.sv
// ============================================================================
// Module   : ddr2_64bit_ex_lfsr8_chk
// Purpose  : Read-side checker for the 8-bit LFSR byte pattern. It self-aligns
//            to the stream, then flags and counts mismatching bytes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr2_64bit_ex_lfsr8_chk #(
    parameter logic [31:0] SEED       = 32'd32,
    parameter int unsigned LOCK_BEATS = 4,
    parameter int unsigned ERR_W      = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             valid_i,
    input  logic [7:0]       data_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             mismatch_o,
    output logic [7:0]       err_mask_o,
    output logic             err_sticky_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    localparam logic [7:0] C_SEED_BYTE = SEED[7:0];
    localparam logic [3:0] C_LOCK_CNT  = LOCK_BEATS[3:0];

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       exp_q, exp_d;
    logic [3:0]       mcnt_q, mcnt_d;
    logic             mismatch_q, mismatch_d;
    logic [7:0]       err_mask_q, err_mask_d;
    logic             err_sticky_q, err_sticky_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    // Galois form of polynomial 0x1D: shift left, fold bit 7 into taps 0,2,3,4.
    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6], x[5], x[4], x[3] ^ x[7], x[2] ^ x[7], x[1] ^ x[7], x[0], x[7]};
    endfunction

    logic [3:0] w_mcnt_inc;
    assign w_mcnt_inc = mcnt_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        mcnt_d       = mcnt_q;
        mismatch_d   = 1'b0;
        err_mask_d   = err_mask_q;
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;

        if (!enable_i) begin
            state_d = ST_IDLE;
            exp_d   = C_SEED_BYTE;
            mcnt_d  = 4'd0;
        end else begin
            if (clear_i) begin
                err_cnt_d    = '0;
                err_sticky_d = 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_HUNT;
                    exp_d   = C_SEED_BYTE;
                    mcnt_d  = 4'd0;
                end
                ST_HUNT: begin
                    if (valid_i) begin
                        if (data_i == exp_q) begin
                            exp_d = lfsr_next(exp_q);
                            if (w_mcnt_inc == C_LOCK_CNT) begin
                                state_d = ST_LOCKED;
                                mcnt_d  = 4'd0;
                            end else begin
                                mcnt_d = w_mcnt_inc;
                            end
                        end else begin
                            // Realign on the received byte and restart the run.
                            exp_d  = lfsr_next(data_i);
                            mcnt_d = 4'd0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (valid_i) begin
                        exp_d = lfsr_next(exp_q);
                        if (data_i != exp_q) begin
                            mismatch_d = 1'b1;
                            err_mask_d = data_i ^ exp_q;
                            // A simultaneous clear wins over counting this beat.
                            if (!clear_i) begin
                                err_sticky_d = 1'b1;
                                if (err_cnt_q != {ERR_W{1'b1}}) begin
                                    err_cnt_d = err_cnt_q + 1'b1;
                                end
                            end
                        end else begin
                            err_mask_d = 8'd0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            exp_q        <= C_SEED_BYTE;
            mcnt_q       <= 4'd0;
            mismatch_q   <= 1'b0;
            err_mask_q   <= 8'd0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            mcnt_q       <= mcnt_d;
            mismatch_q   <= mismatch_d;
            err_mask_q   <= err_mask_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign locked_o     = (state_q == ST_LOCKED);
    assign mismatch_o   = mismatch_q;
    assign err_mask_o   = err_mask_q;
    assign err_sticky_o = err_sticky_q;
    assign err_cnt_o    = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ddr2_64bit_ex_lfsr8_chk.sv
// ============================================================================
// Module   : tb_ddr2_64bit_ex_lfsr8_chk
// Purpose  : Directed bench for the LFSR8 checker; a second instance with a
//            2-bit error counter exercises saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ddr2_64bit_ex_lfsr8_chk;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        valid;
    logic [7:0]  data;
    logic        clear;

    logic        a_locked, a_mismatch, a_sticky;
    logic [7:0]  a_mask;
    logic [15:0] a_cnt;
    logic        b_locked, b_mismatch, b_sticky;
    logic [7:0]  b_mask;
    logic [1:0]  b_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ddr2_64bit_ex_lfsr8_chk #(.SEED(32'd32), .LOCK_BEATS(4), .ERR_W(16)) u_dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .valid_i(valid),
        .data_i(data), .clear_i(clear),
        .locked_o(a_locked), .mismatch_o(a_mismatch), .err_mask_o(a_mask),
        .err_sticky_o(a_sticky), .err_cnt_o(a_cnt)
    );

    ddr2_64bit_ex_lfsr8_chk #(.SEED(32'd32), .LOCK_BEATS(4), .ERR_W(2)) u_sat (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .valid_i(valid),
        .data_i(data), .clear_i(clear),
        .locked_o(b_locked), .mismatch_o(b_mismatch), .err_mask_o(b_mask),
        .err_sticky_o(b_sticky), .err_cnt_o(b_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d);
        valid = 1'b1;
        data  = d;
        cycle();
        valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_locked"},   a_locked,   0);
        check_eq({tag, "_mismatch"}, a_mismatch, 0);
        check_eq({tag, "_mask"},     a_mask,     0);
        check_eq({tag, "_sticky"},   a_sticky,   0);
        check_eq({tag, "_cnt"},      a_cnt,      0);
        check_eq({tag, "_sat_cnt"},  b_cnt,      0);
    endtask

    logic [7:0] sat_data [5] = '{8'h4D, 8'h99, 8'h2C, 8'h5B, 8'hB5};
    logic [1:0] sat_cnt  [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        reset = 1'b1; enable = 1'b0; valid = 1'b0; data = 8'h00; clear = 1'b0;
        cycle();
        cycle();
        check_reset_vals("reset");

        reset = 1'b0; enable = 1'b1;
        cycle();
        check_eq("idle_to_hunt_locked", a_locked, 0);

        // Aligned start from the seed.
        beat(8'h20); check_eq("align_b1_locked", a_locked, 0);
        beat(8'h40);
        beat(8'h80); check_eq("align_b3_locked", a_locked, 0);
        beat(8'h1D);
        check_eq("align_b4_locked",   a_locked,   1);
        check_eq("align_b4_mismatch", a_mismatch, 0);
        check_eq("align_b4_cnt",      a_cnt,      0);

        // Single-bit error where 0x3A is expected.
        beat(8'h3B);
        check_eq("sbe_mismatch", a_mismatch, 1);
        check_eq("sbe_mask",     a_mask,     8'h01);
        check_eq("sbe_cnt",      a_cnt,      1);
        check_eq("sbe_sticky",   a_sticky,   1);
        check_eq("sbe_locked",   a_locked,   1);
        cycle();
        check_eq("sbe_pulse_end", a_mismatch, 0);
        check_eq("sbe_mask_held", a_mask,     8'h01);
        beat(8'h74);
        check_eq("sbe_next_mismatch", a_mismatch, 0);
        check_eq("sbe_next_mask",     a_mask,     8'h00);
        check_eq("sbe_next_cnt",      a_cnt,      1);

        // Gaps must not advance the expected value.
        cycle();
        cycle();
        beat(8'hE8);
        check_eq("gap_mismatch", a_mismatch, 0);
        clear = 1'b1; cycle(); clear = 1'b0;
        check_eq("clear_cnt",    a_cnt,    0);
        check_eq("clear_sticky", a_sticky, 0);

        // Three-beat burst error.
        beat(8'h32); check_eq("burst1_mask", a_mask, 8'hFF);
        beat(8'h97); check_eq("burst2_mask", a_mask, 8'h10);
        beat(8'h12);
        check_eq("burst3_mask",     a_mask,     8'h01);
        check_eq("burst3_mismatch", a_mismatch, 1);
        check_eq("burst_cnt",       a_cnt,      3);
        check_eq("burst_locked",    a_locked,   1);
        check_eq("burst_sat_cnt",   b_cnt,      3);
        beat(8'h26);
        check_eq("post_burst_mismatch", a_mismatch, 0);

        // Saturation of the 2-bit counter.
        clear = 1'b1; cycle(); clear = 1'b0;
        check_eq("sat_clear_cnt", b_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            beat(sat_data[i]);
            check_eq($sformatf("sat_cnt_%0d", i), b_cnt, sat_cnt[i]);
        end
        check_eq("sat_sticky", b_sticky, 1);
        check_eq("sat_wide_cnt", a_cnt, 5);

        // Clear coinciding with a mismatching beat.
        clear = 1'b1;
        beat(8'h77);
        clear = 1'b0;
        check_eq("clr_err_cnt",      b_cnt,      0);
        check_eq("clr_err_sticky",   b_sticky,   0);
        check_eq("clr_err_mismatch", b_mismatch, 1);
        check_eq("clr_err_mask",     b_mask,     8'h02);
        check_eq("clr_err_wide_cnt", a_cnt,      0);

        // Disable while locked: errors held, clear ignored, beat ignored.
        beat(8'hEE);
        check_eq("pre_dis_cnt", a_cnt, 1);
        enable = 1'b0; clear = 1'b1;
        beat(8'h00);
        clear = 1'b0;
        check_eq("dis_locked",   a_locked,   0);
        check_eq("dis_cnt",      a_cnt,      1);
        check_eq("dis_sticky",   a_sticky,   1);
        check_eq("dis_mismatch", a_mismatch, 0);
        enable = 1'b1;
        cycle();
        beat(8'h20);
        beat(8'h40);
        beat(8'h80); check_eq("reen_b3_locked", a_locked, 0);
        beat(8'h1D); check_eq("reen_b4_locked", a_locked, 1);
        beat(8'hBA);
        check_eq("reen_err_mask", a_mask, 8'h80);
        check_eq("reen_err_cnt",  a_cnt,  2);

        // Reset mid-stream.
        reset = 1'b1;
        cycle();
        check_reset_vals("midrst");
        reset = 1'b0;
        cycle();
        beat(8'h20);
        beat(8'h40);
        beat(8'h80); check_eq("rst_relock_b3", a_locked, 0);
        beat(8'h1D); check_eq("rst_relock_b4", a_locked, 1);

        // Mid-sequence start: first beat realigns.
        reset = 1'b1; cycle(); reset = 1'b0; cycle();
        beat(8'h80);
        check_eq("mid_b1_mismatch", a_mismatch, 0);
        check_eq("mid_b1_locked",   a_locked,   0);
        beat(8'h1D);
        beat(8'h3A);
        beat(8'h74); check_eq("mid_b4_locked", a_locked, 0);
        beat(8'hE8);
        check_eq("mid_b5_locked", a_locked, 1);
        check_eq("mid_cnt",       a_cnt,    0);
        check_eq("mid_sticky",    a_sticky, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
